std_exe_unit_q: RTL and testbench
=================================

// Module: std_exe_unit_q
// PURPOSE
// - Parametrised store-data execution unit: NUM_IN issue ports feed a round-robin arbiter and a DEPTH-entry collapsing output queue.
// - Formats store data (STD) or passes through MOU operands. Flushes queued uops younger than a redirect.
// - Sits between the int issue queues and the store queue data-write port, replacing the single-port, unbuffered StdExeUnit.
// PARAMETERS
// - XLEN       64  data width
// - ROB_IDX_W  5   robIdx value width
// - SQ_IDX_W   4   sqIdx value width
// - NUM_IN     2   issue ports, >=1
// - DEPTH      4   output queue entries, >=2
// PORTS
// - clock                  in   1                 single clock, rising edge
// - reset                  in   1                 asynchronous, active-low
// - io_in_valid            in   NUM_IN            per-port uop valid
// - io_in_ready            out  NUM_IN            per-port accept
// - io_in_fuType           in   NUM_IN*4          bit0=STD, bit1=MOU
// - io_in_fuOpType         in   NUM_IN*7          [1:0] size: 0=B,1=H,2=W,3=D
// - io_in_robIdx_flag      in   NUM_IN            ROB wrap flag
// - io_in_robIdx_value     in   NUM_IN*ROB_IDX_W  ROB index
// - io_in_sqIdx_flag       in   NUM_IN            SQ wrap flag
// - io_in_sqIdx_value      in   NUM_IN*SQ_IDX_W   SQ index
// - io_in_src0             in   NUM_IN*XLEN       store data operand
// - io_redirect_valid      in   1                 flush request
// - io_redirect_robIdx     in   1+ROB_IDX_W       {flag,value}
// - io_redirect_level      in   1                 1 = also flush the equal robIdx
// - io_out_valid           out  1                 head valid
// - io_out_ready           in   1                 consumer accept
// - io_out_fuType/fuOpType/robIdx/sqIdx  out  as in  head uop fields
// - io_out_data            out  XLEN              formatted data
// - io_illegal             out  1                 pulse: accepted uop with fuType[1:0]==0 was dropped
// - io_count               out  $clog2(DEPTH+1)   occupied entries
// BEHAVIOUR
// - Reset: all queue entries invalid; io_out_valid=0, io_count=0, io_illegal=0; RR pointer=0; io_in_ready follows the arbiter and is combinational.
// - Arbitration: at most one enqueue per cycle.
//   - Grant goes to the first valid port at or after the RR pointer.
//   - The pointer moves to grant+1 (mod NUM_IN) only on enqueue.
// - io_in_ready[i] = grant[i] & (count<DEPTH). There is no same-cycle enqueue bypass when full. Ungranted ports see ready=0.
// - Data formatting, registered into the queue:
//   - STD: B replicates src0[7:0] x8, H replicates [15:0] x4, W replicates [31:0] x2, D passes through.
//   - MOU: src0 unchanged. If both fuType bits are set, STD wins.
// - Illegal fuType (bits[1:0]==0): the uop is accepted and dropped; io_illegal=1 the next cycle.
// - Latency: accept at cycle N gives earliest io_out_valid at N+1. One dequeue per cycle, on io_out_valid & io_out_ready.
// - Queue order is arrival order (collapsing shift). A dequeue and an enqueue in the same cycle are both legal; count is unchanged.
// - Age compare: isAfter(a,b) = (a.flag ^ b.flag) ^ (a.value > b.value).
// - Kill(e) = redirect_valid & (isAfter(e,redir) | (level & e==redir)).
// - Redirect handling:
//   - Killed entries are removed next cycle; survivors compact toward the head in order.
//   - An incoming uop that meets Kill is not enqueued, though io_in_ready stays as computed.
//   - io_out_valid = head_valid & ~Kill(head), combinationally.
// - io_count counts valid entries after the previous edge.
// - Reset assertion mid-operation clears everything immediately. On release the block restarts as after reset.
// CONFIGURATION
// - STD_EXE_PERF_EN defined: adds outputs io_perf_enq, io_perf_flush, io_perf_full (32 bits each).
//   - They count enqueues, killed entries (popcount per cycle, incoming kill included), and cycles with count==DEPTH.
//   - Counters saturate at all-ones and reset to 0.
// - STD_EXE_PERF_EN undefined: no perf ports and no counter logic.
// STRUCTURE
// - Package std_exe_pkg holds:
//   - size localparams SZ_B/H/W/D; FU_STD=0 and FU_MOU=1 bit indices;
//   - typedef std_uop_t {fuType,fuOpType,robIdx,sqIdx};
//   - function is_after(); function fmt_data(size,src).
// - Sub-module std_exe_rr_arb(NUM_IN) provides the round-robin grant and the pointer register.
// - Top holds the queue, kill logic and perf counters.
// TESTING
// - Reset: hold reset low with in_valid set -> out_valid=0, count=0. After release, first accept shows at out at N+1.
// - Formatting: STD size B, src0=0x..AB -> data 0xABABABABABABABAB; W 0x1234_5678 -> 0x1234567812345678; MOU -> src0 unchanged.
// - RR fairness: both ports valid for 4 cycles, out_ready=1 -> grants 0,1,0,1; each port's ready toggles.
// - Full: out_ready=0, 5 accepts offered -> count=4 and in_ready=0. Then out_ready=1 for one cycle -> count=3 and an enqueue resumes the next cycle.
// - Flush: queue robIdx {0:3,0:5,0:7,1:1}, redirect {0,5} level=0 -> {0:3,0:5} remain in order. With level=1 -> only {0:3} remains.
// - Head kill plus illegal: redirect kills the head with out_ready=1 -> no dequeue that cycle. A fuType=0 uop -> io_illegal pulses once, count unchanged.

Source files
------------

// File: rtl/std_exe_pkg.sv
// Shared types and helpers for the store-data execution unit: uop fields,
// ROB age comparison and store-data size formatting.
package std_exe_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam int FU_STD = 0;
    localparam int FU_MOU = 1;

    // Index fields are stored at a fixed maximum width; narrower indices are
    // zero-extended, which preserves the magnitude compare in is_after().
    localparam int IDX_MAX_W = 16;

    typedef struct packed {
        logic                 flag;
        logic [IDX_MAX_W-1:0] value;
    } idx_t;

    typedef struct packed {
        logic [3:0] fuType;
        logic [6:0] fuOpType;
        idx_t       robIdx;
        idx_t       sqIdx;
    } std_uop_t;

    function automatic logic is_after(idx_t a, idx_t b);
        return (a.flag ^ b.flag) ^ (a.value > b.value);
    endfunction

    function automatic logic [63:0] fmt_data(logic [1:0] size, logic [63:0] src);
        case (size)
            SZ_B:    return {8{src[7:0]}};
            SZ_H:    return {4{src[15:0]}};
            SZ_W:    return {2{src[31:0]}};
            default: return src;
        endcase
    endfunction

endpackage

// File: rtl/std_exe_rr_arb.sv
// Round-robin grant: first requesting port at or after the pointer wins.
// Zero latency (combinational grant); pointer moves past the winner only when adv is high.
module std_exe_rr_arb #(
    parameter int NUM_IN = 2,
    localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_IN-1:0] req,
    input  logic              adv,
    output logic [NUM_IN-1:0] grant,
    output logic [PTR_W-1:0]  grant_idx
);

    logic [PTR_W-1:0] ptr;
    logic             found;
    int               idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_IN; i++) begin
            idx = (int'(ptr) + i) % NUM_IN;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PTR_W'(idx);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= (grant_idx == PTR_W'(NUM_IN - 1)) ? '0 : grant_idx + PTR_W'(1);
        end
    end

endmodule

// File: rtl/std_exe_unit_q.sv
// Store-data execution unit: NUM_IN issue ports, round-robin pick, DEPTH-entry collapsing queue.
// Latency 1 (accept at N -> out valid at N+1); in_ready drops when the queue is full, no bypass.
// Optional perf counters under STD_EXE_PERF_EN.
module std_exe_unit_q
    import std_exe_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int ROB_IDX_W = 5,
    parameter int SQ_IDX_W  = 4,
    parameter int NUM_IN    = 2,
    parameter int DEPTH     = 4,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_IN-1:0]             io_in_valid,
    output logic [NUM_IN-1:0]             io_in_ready,
    input  logic [NUM_IN*4-1:0]           io_in_fuType,
    input  logic [NUM_IN*7-1:0]           io_in_fuOpType,
    input  logic [NUM_IN-1:0]             io_in_robIdx_flag,
    input  logic [NUM_IN*ROB_IDX_W-1:0]   io_in_robIdx_value,
    input  logic [NUM_IN-1:0]             io_in_sqIdx_flag,
    input  logic [NUM_IN*SQ_IDX_W-1:0]    io_in_sqIdx_value,
    input  logic [NUM_IN*XLEN-1:0]        io_in_src0,
    input  logic                          io_redirect_valid,
    input  logic [ROB_IDX_W:0]            io_redirect_robIdx,
    input  logic                          io_redirect_level,
    output logic                          io_out_valid,
    input  logic                          io_out_ready,
    output logic [3:0]                    io_out_fuType,
    output logic [6:0]                    io_out_fuOpType,
    output logic                          io_out_robIdx_flag,
    output logic [ROB_IDX_W-1:0]          io_out_robIdx_value,
    output logic                          io_out_sqIdx_flag,
    output logic [SQ_IDX_W-1:0]           io_out_sqIdx_value,
    output logic [XLEN-1:0]               io_out_data,
    output logic                          io_illegal,
    output logic [CNT_W-1:0]              io_count
`ifdef STD_EXE_PERF_EN
    ,
    output logic [31:0]                   io_perf_enq,
    output logic [31:0]                   io_perf_flush,
    output logic [31:0]                   io_perf_full
`endif
);

    localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    logic [DEPTH-1:0] q_vld;
    std_uop_t         q_uop  [DEPTH];
    logic [XLEN-1:0]  q_data [DEPTH];

    logic [DEPTH-1:0] n_vld;
    std_uop_t         n_uop  [DEPTH];
    logic [XLEN-1:0]  n_data [DEPTH];

    logic [NUM_IN-1:0] grant;
    logic [PTR_W-1:0]  grant_idx;
    logic              full;
    logic              accept;
    logic              legal;
    logic              kill_in;
    logic              enq;
    logic              deq;
    logic [DEPTH-1:0]  kill;
    idx_t              redir;
    std_uop_t          in_uop;
    logic [XLEN-1:0]   in_src;
    logic [XLEN-1:0]   in_fmt;
    int                wr;

    std_exe_rr_arb #(.NUM_IN(NUM_IN)) u_arb (
        .clock     (clock),
        .reset     (reset),
        .req       (io_in_valid),
        .adv       (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        io_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            io_count = io_count + CNT_W'(q_vld[i]);
        end
    end

    assign full        = (io_count == CNT_W'(DEPTH));
    assign io_in_ready = grant & {NUM_IN{~full}};
    assign accept      = |grant & ~full;

    always_comb begin
        in_uop = '0;
        in_src = '0;
        for (int g = 0; g < NUM_IN; g++) begin
            if (grant[g]) begin
                in_uop.fuType       = io_in_fuType[g*4 +: 4];
                in_uop.fuOpType     = io_in_fuOpType[g*7 +: 7];
                in_uop.robIdx.flag  = io_in_robIdx_flag[g];
                in_uop.robIdx.value = IDX_MAX_W'(io_in_robIdx_value[g*ROB_IDX_W +: ROB_IDX_W]);
                in_uop.sqIdx.flag   = io_in_sqIdx_flag[g];
                in_uop.sqIdx.value  = IDX_MAX_W'(io_in_sqIdx_value[g*SQ_IDX_W +: SQ_IDX_W]);
                in_src              = io_in_src0[g*XLEN +: XLEN];
            end
        end
    end

    // STD takes priority when both unit bits are set; MOU operands pass untouched.
    assign in_fmt = in_uop.fuType[FU_STD] ? XLEN'(fmt_data(in_uop.fuOpType[1:0], 64'(in_src)))
                                          : in_src;

    assign redir.flag  = io_redirect_robIdx[ROB_IDX_W];
    assign redir.value = IDX_MAX_W'(io_redirect_robIdx[ROB_IDX_W-1:0]);

    assign kill_in = io_redirect_valid &
                     (is_after(in_uop.robIdx, redir) | (io_redirect_level & (in_uop.robIdx == redir)));

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            kill[i] = q_vld[i] & io_redirect_valid &
                      (is_after(q_uop[i].robIdx, redir) |
                       (io_redirect_level & (q_uop[i].robIdx == redir)));
        end
    end

    assign legal        = |in_uop.fuType[1:0];
    assign enq          = accept & legal & ~kill_in;
    assign io_out_valid = q_vld[0] & ~kill[0];
    assign deq          = io_out_valid & io_out_ready;

    // Collapse survivors toward the head in arrival order, then append the new uop.
    always_comb begin
        n_vld = '0;
        wr    = 0;
        for (int i = 0; i < DEPTH; i++) begin
            n_uop[i]  = q_uop[i];
            n_data[i] = q_data[i];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (q_vld[i] && !kill[i] && !(i == 0 && deq)) begin
                n_vld[wr]  = 1'b1;
                n_uop[wr]  = q_uop[i];
                n_data[wr] = q_data[i];
                wr         = wr + 1;
            end
        end
        if (enq && wr < DEPTH) begin
            n_vld[wr]  = 1'b1;
            n_uop[wr]  = in_uop;
            n_data[wr] = in_fmt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_vld      <= '0;
            io_illegal <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                q_uop[i]  <= '0;
                q_data[i] <= '0;
            end
        end else begin
            q_vld      <= n_vld;
            io_illegal <= accept & ~legal;
            for (int i = 0; i < DEPTH; i++) begin
                q_uop[i]  <= n_uop[i];
                q_data[i] <= n_data[i];
            end
        end
    end

    assign io_out_fuType       = q_uop[0].fuType;
    assign io_out_fuOpType     = q_uop[0].fuOpType;
    assign io_out_robIdx_flag  = q_uop[0].robIdx.flag;
    assign io_out_robIdx_value = q_uop[0].robIdx.value[ROB_IDX_W-1:0];
    assign io_out_sqIdx_flag   = q_uop[0].sqIdx.flag;
    assign io_out_sqIdx_value  = q_uop[0].sqIdx.value[SQ_IDX_W-1:0];
    assign io_out_data         = q_data[0];

`ifdef STD_EXE_PERF_EN
    function automatic logic [31:0] sat_add(logic [31:0] c, logic [31:0] inc);
        logic [32:0] sum;
        sum = {1'b0, c} + {1'b0, inc};
        return sum[32] ? '1 : sum[31:0];
    endfunction

    logic [31:0] flush_inc;

    // Incoming uops killed at the door count as flushed, alongside queued victims.
    always_comb begin
        flush_inc = 32'(accept & legal & kill_in);
        for (int i = 0; i < DEPTH; i++) begin
            flush_inc = flush_inc + 32'(kill[i]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_perf_enq   <= '0;
            io_perf_flush <= '0;
            io_perf_full  <= '0;
        end else begin
            io_perf_enq   <= sat_add(io_perf_enq, 32'(enq));
            io_perf_flush <= sat_add(io_perf_flush, flush_inc);
            io_perf_full  <= sat_add(io_perf_full, 32'(full));
        end
    end
`endif

endmodule

// File: tb/tb_std_exe_unit_q.sv
// Directed bench for std_exe_unit_q: reset, formatting, round-robin, full, flush, head kill, illegal.
module tb_std_exe_unit_q;

    logic         clock;
    logic         reset;
    logic [1:0]   in_valid;
    logic [1:0]   in_ready;
    logic [7:0]   in_fuType;
    logic [13:0]  in_fuOpType;
    logic [1:0]   in_rob_flag;
    logic [9:0]   in_rob_value;
    logic [1:0]   in_sq_flag;
    logic [7:0]   in_sq_value;
    logic [127:0] in_src0;
    logic         redirect_valid;
    logic [5:0]   redirect_rob;
    logic         redirect_level;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   out_fuType;
    logic [6:0]   out_fuOpType;
    logic         out_rob_flag;
    logic [4:0]   out_rob_value;
    logic         out_sq_flag;
    logic [3:0]   out_sq_value;
    logic [63:0]  out_data;
    logic         illegal;
    logic [2:0]   count;

    int checks   = 0;
    int failures = 0;

    std_exe_unit_q dut (
        .clock               (clock),
        .reset               (reset),
        .io_in_valid         (in_valid),
        .io_in_ready         (in_ready),
        .io_in_fuType        (in_fuType),
        .io_in_fuOpType      (in_fuOpType),
        .io_in_robIdx_flag   (in_rob_flag),
        .io_in_robIdx_value  (in_rob_value),
        .io_in_sqIdx_flag    (in_sq_flag),
        .io_in_sqIdx_value   (in_sq_value),
        .io_in_src0          (in_src0),
        .io_redirect_valid   (redirect_valid),
        .io_redirect_robIdx  (redirect_rob),
        .io_redirect_level   (redirect_level),
        .io_out_valid        (out_valid),
        .io_out_ready        (out_ready),
        .io_out_fuType       (out_fuType),
        .io_out_fuOpType     (out_fuOpType),
        .io_out_robIdx_flag  (out_rob_flag),
        .io_out_robIdx_value (out_rob_value),
        .io_out_sqIdx_flag   (out_sq_flag),
        .io_out_sqIdx_value  (out_sq_value),
        .io_out_data         (out_data),
        .io_illegal          (illegal),
        .io_count            (count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic set_port(input int p, input logic v, input logic [3:0] fu, input logic [6:0] op,
                            input logic rf, input logic [4:0] rv, input logic [3:0] sv,
                            input logic [63:0] src);
        in_valid[p]            = v;
        in_fuType[p*4 +: 4]    = fu;
        in_fuOpType[p*7 +: 7]  = op;
        in_rob_flag[p]         = rf;
        in_rob_value[p*5 +: 5] = rv;
        in_sq_flag[p]          = 1'b0;
        in_sq_value[p*4 +: 4]  = sv;
        in_src0[p*64 +: 64]    = src;
    endtask

    task automatic fill4();
        logic       rf_tab [4];
        logic [4:0] rv_tab [4];
        rf_tab = '{1'b0, 1'b0, 1'b0, 1'b1};
        rv_tab = '{5'd3, 5'd5, 5'd7, 5'd1};
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_port(0, 1'b1, 4'd1, 7'd3, rf_tab[k], rv_tab[k], 4'(k), 64'(k));
            cyc();
        end
        in_valid = 2'b00;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 2'b00;
        for (int k = 0; k < 8 && count != 0; k++) cyc();
        chk("drain_count", 64'(count), 64'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        reset          = 1'b0;
        in_valid       = '0;
        in_fuType      = '0;
        in_fuOpType    = '0;
        in_rob_flag    = '0;
        in_rob_value   = '0;
        in_sq_flag     = '0;
        in_sq_value    = '0;
        in_src0        = '0;
        redirect_valid = 1'b0;
        redirect_rob   = '0;
        redirect_level = 1'b0;
        out_ready      = 1'b0;

        // Reset held with valid inputs: nothing may enter the queue.
        set_port(0, 1'b1, 4'd1, 7'd3, 1'b0, 5'd9, 4'd1, 64'h1);
        set_port(1, 1'b1, 4'd1, 7'd3, 1'b0, 5'd9, 4'd1, 64'h2);
        cyc(); cyc(); cyc();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_illegal", 64'(illegal), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'b01);
        in_valid = 2'b00;
        reset = 1'b1;

        // STD byte on port 0
        set_port(0, 1'b1, 4'd1, 7'd0, 1'b0, 5'd3, 4'd5, 64'h0123456789ABCDAB);
        #1;
        chk("a_in_ready", 64'(in_ready), 64'b01);
        chk("a_pre_out_valid", 64'(out_valid), 64'd0);
        cyc();
        in_valid = 2'b00;
        chk("a_out_valid", 64'(out_valid), 64'd1);
        chk("a_count", 64'(count), 64'd1);
        chk("a_data_b", out_data, 64'hABABABABABABABAB);
        chk("a_rob", 64'(out_rob_value), 64'd3);
        chk("a_sq", 64'(out_sq_value), 64'd5);

        // STD word on port 1 (pointer now 1)
        set_port(1, 1'b1, 4'd1, 7'd2, 1'b0, 5'd4, 4'd6, 64'hDEADBEEF12345678);
        #1;
        chk("b_in_ready", 64'(in_ready), 64'b10);
        cyc();
        in_valid = 2'b00;
        chk("b_count", 64'(count), 64'd2);
        chk("b_head_data", out_data, 64'hABABABABABABABAB);
        out_ready = 1'b1;
        cyc();
        chk("b_deq_count", 64'(count), 64'd1);
        chk("b_data_w", out_data, 64'h1234567812345678);
        chk("b_rob", 64'(out_rob_value), 64'd4);

        // MOU passthrough, simultaneous enqueue and dequeue
        set_port(1, 1'b1, 4'd2, 7'd3, 1'b0, 5'd5, 4'd7, 64'hCAFE000012345601);
        cyc();
        in_valid = 2'b00;
        chk("mou_count", 64'(count), 64'd1);
        chk("mou_data", out_data, 64'hCAFE000012345601);
        chk("mou_futype", 64'(out_fuType), 64'd2);
        cyc();
        chk("mou_empty_count", 64'(count), 64'd0);
        chk("mou_empty_valid", 64'(out_valid), 64'd0);

        // Round robin: both ports valid for four cycles
        set_port(0, 1'b1, 4'd1, 7'd3, 1'b0, 5'd1, 4'd1, 64'h0F0E0D0C0B0A0908);
        set_port(1, 1'b1, 4'd3, 7'd1, 1'b0, 5'd2, 4'd2, 64'h000000000000BEEF);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_in_ready", 64'(in_ready), (k % 2 == 0) ? 64'b01 : 64'b10);
            cyc();
            chk("rr_head_data", out_data, (k % 2 == 0) ? 64'h0F0E0D0C0B0A0908 : 64'hBEEFBEEFBEEFBEEF);
        end
        chk("rr_count", 64'(count), 64'd1);
        drain();

        // Full: four accepts, the fifth is refused
        fill4();
        set_port(0, 1'b1, 4'd1, 7'd3, 1'b0, 5'd2, 4'd9, 64'h99);
        #1;
        chk("full_count", 64'(count), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'b00);
        cyc();
        chk("full_hold_count", 64'(count), 64'd4);
        out_ready = 1'b1;
        #1;
        chk("full_no_bypass", 64'(in_ready), 64'b00);
        cyc();
        out_ready = 1'b0;
        chk("full_deq_count", 64'(count), 64'd3);
        chk("full_resume_ready", 64'(in_ready), 64'b01);
        cyc();
        in_valid = 2'b00;
        chk("full_resume_count", 64'(count), 64'd4);
        drain();

        // Flush level 0: redirect {0,5} keeps {0:3,0:5}
        fill4();
        redirect_valid = 1'b1;
        redirect_rob   = {1'b0, 5'd5};
        redirect_level = 1'b0;
        #1;
        chk("fl0_out_valid", 64'(out_valid), 64'd1);
        cyc();
        redirect_valid = 1'b0;
        chk("fl0_count", 64'(count), 64'd2);
        chk("fl0_head", 64'(out_rob_value), 64'd3);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("fl0_second", {63'd0, out_rob_flag} << 5 | 64'(out_rob_value), 64'd5);
        chk("fl0_second_count", 64'(count), 64'd1);
        drain();

        // Flush level 1: equal robIdx also goes
        fill4();
        redirect_valid = 1'b1;
        redirect_rob   = {1'b0, 5'd5};
        redirect_level = 1'b1;
        cyc();
        redirect_valid = 1'b0;
        redirect_level = 1'b0;
        chk("fl1_count", 64'(count), 64'd1);
        chk("fl1_head", 64'(out_rob_value), 64'd3);
        drain();

        // Head kill: queue {0:5},{0:2}, redirect {0,4} kills head and the incoming {0:6}
        set_port(0, 1'b1, 4'd1, 7'd3, 1'b0, 5'd5, 4'd1, 64'h5);
        cyc();
        set_port(0, 1'b1, 4'd1, 7'd3, 1'b0, 5'd2, 4'd2, 64'h2);
        cyc();
        set_port(0, 1'b1, 4'd1, 7'd3, 1'b0, 5'd6, 4'd3, 64'h6);
        redirect_valid = 1'b1;
        redirect_rob   = {1'b0, 5'd4};
        out_ready      = 1'b1;
        #1;
        chk("hk_out_valid", 64'(out_valid), 64'd0);
        chk("hk_in_ready", 64'(in_ready), 64'b01);
        cyc();
        in_valid       = 2'b00;
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        chk("hk_count", 64'(count), 64'd1);
        chk("hk_head", 64'(out_rob_value), 64'd2);

        // Illegal fuType: accepted, dropped, one-cycle pulse
        set_port(0, 1'b1, 4'd0, 7'd3, 1'b0, 5'd8, 4'd4, 64'h8);
        #1;
        chk("ill_in_ready", 64'(in_ready), 64'b01);
        cyc();
        in_valid = 2'b00;
        chk("ill_pulse", 64'(illegal), 64'd1);
        chk("ill_count", 64'(count), 64'd1);
        cyc();
        chk("ill_clear", 64'(illegal), 64'd0);
        chk("ill_count2", 64'(count), 64'd1);

        // Mid-run reset clears immediately, then restart
        reset = 1'b0;
        #1;
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        cyc();
        reset = 1'b1;
        set_port(0, 1'b1, 4'd1, 7'd3, 1'b0, 5'd1, 4'd1, 64'h1122334455667788);
        cyc();
        in_valid = 2'b00;
        chk("restart_count", 64'(count), 64'd1);
        chk("restart_data", out_data, 64'h1122334455667788);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
